// File: rtl/pin_bus_responder.sv
// Far-end responder for the CPU external memory bus at the TinyTapeout pins.
// Four-phase strobe/ack handshake in front of a byte memory that a host port can preload.
module pin_bus_responder #(
   parameter int MEM_AW      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cpu_ctrl,
   input  logic [7:0]        cpu_data,
   input  logic [7:0]        cpu_oe,
   output logic [7:0]        rsp_data,
   output logic              rsp_ack,
   input  logic              host_we,
   input  logic [MEM_AW-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic              host_ready,
   output logic [15:0]       addr_q,
   output logic              proto_err
);

   localparam int DEPTH = 1 << MEM_AW;

   localparam logic [3:0] CMD_AH = 4'b0001;
   localparam logic [3:0] CMD_AL = 4'b0010;
   localparam logic [3:0] CMD_RD = 4'b0100;
   localparam logic [3:0] CMD_WR = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_ACK     = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
   endfunction

   state_t              state_q, state_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [15:0]         addr_d;
   logic [7:0]          rsp_data_q, rsp_data_d;
   logic                rsp_ack_q, rsp_ack_d;
   logic                proto_err_q, proto_err_d;
   logic [7:0]          mem_q [0:DEPTH-1];
   logic                mem_we_d;
   logic [MEM_AW-1:0]   mem_waddr_d;
   logic [7:0]          mem_wdata_d;
   logic                strobe_held;
   logic [MEM_AW-1:0]   mem_idx;

   assign strobe_held = |(cpu_ctrl & cmd_q);
   assign mem_idx     = addr_q[MEM_AW-1:0];
   assign host_ready  = (state_q == S_IDLE) && (cpu_ctrl == 4'h0);
   assign rsp_data    = rsp_data_q;
   assign rsp_ack     = rsp_ack_q;
   assign proto_err   = proto_err_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (is_onehot4(cpu_ctrl)) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!strobe_held) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_ACK: begin
            if (cpu_ctrl == 4'h0) begin
               state_d = S_RELEASE;
            end else begin
               state_d = S_ACK;
            end
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output and datapath logic; the command executes on the edge that raises ack
   always_comb begin
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rsp_data_d  = rsp_data_q;
      rsp_ack_d   = rsp_ack_q;
      proto_err_d = proto_err_q;
      mem_we_d    = host_we && host_ready;
      mem_waddr_d = host_addr;
      mem_wdata_d = host_wdata;
      case (state_q)
         S_IDLE: begin
            rsp_ack_d = 1'b0;
            if (is_onehot4(cpu_ctrl)) begin
               cmd_d = cpu_ctrl;
               cnt_d = 4'(WAIT_CYCLES);
            end else if (cpu_ctrl != 4'h0) begin
               proto_err_d = 1'b1;
            end else begin
               cmd_d = cmd_q;
            end
         end
         S_WAIT: begin
            if (!strobe_held) begin
               proto_err_d = 1'b1;
            end else if (cnt_q == 4'd0) begin
               rsp_ack_d = 1'b1;
               case (cmd_q)
                  CMD_AH: begin
                     addr_d[15:8] = cpu_data;
                     if (cpu_oe != 8'hFF) proto_err_d = 1'b1; else proto_err_d = proto_err_q;
                  end
                  CMD_AL: begin
                     addr_d[7:0] = cpu_data;
                     if (cpu_oe != 8'hFF) proto_err_d = 1'b1; else proto_err_d = proto_err_q;
                  end
                  CMD_RD: begin
                     rsp_data_d = mem_q[mem_idx];
                     addr_d     = addr_q + 16'd1;
                     if (cpu_oe != 8'h00) proto_err_d = 1'b1; else proto_err_d = proto_err_q;
                  end
                  CMD_WR: begin
                     mem_we_d    = 1'b1;
                     mem_waddr_d = mem_idx;
                     mem_wdata_d = cpu_data;
                     addr_d      = addr_q + 16'd1;
                     if (cpu_oe != 8'hFF) proto_err_d = 1'b1; else proto_err_d = proto_err_q;
                  end
                  default: addr_d = addr_q;
               endcase
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            if (cpu_ctrl == 4'h0) begin
               rsp_ack_d = 1'b0;
            end else begin
               rsp_ack_d = 1'b1;
            end
         end
         S_RELEASE: rsp_ack_d = 1'b0;
         default:   rsp_ack_d = 1'b0;
      endcase
   end

   // Datapath and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q       <= 4'h0;
         cnt_q       <= 4'd0;
         addr_q      <= 16'h0000;
         rsp_data_q  <= 8'h00;
         rsp_ack_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rsp_data_q  <= rsp_data_d;
         rsp_ack_q   <= rsp_ack_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Backing memory keeps its contents across reset so preloaded programs survive
   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[mem_waddr_d] <= mem_wdata_d;
      end
   end

endmodule
